// File: rtl/rd_fifo_ctrl_pkg.sv
// Shared definitions for the read-side FIFO sequencer: state encoding and level width.
package rd_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StArmed   = 2'd1,
        StReady   = 2'd2,
        StRelease = 2'd3
    } rd_state_e;

    // level counts 0..MEM_DEPTH inclusive, so it needs one bit more than the address
    function automatic int unsigned lvl_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/rd_fifo_ctrl.sv
// Read-side sequencer: detects a bank reload (full falling), hands out MEM_DEPTH entries in
// address order, pulses release when drained and keeps sticky overflow/underflow flags.
module rd_fifo_ctrl
    import rd_fifo_ctrl_pkg::*;
#(
    parameter int unsigned RD_ADDR_WIDTH = 2,
    parameter int unsigned MEM_DEPTH     = 4
) (
    input  logic                                  rd_clk_i,
    input  logic                                  reset_ni,
    input  logic                                  full_i,
    input  logic                                  flush_i,
    input  logic                                  rd_req_i,
    input  logic                                  err_clr_i,
    output logic                                  rd_en_o,
    output logic [RD_ADDR_WIDTH-1:0]              rd_addr_o,
    output logic                                  rd_valid_o,
    output logic                                  empty_o,
    output logic [lvl_width(RD_ADDR_WIDTH)-1:0]   level_o,
    output logic                                  release_o,
    output logic                                  ovf_err_o,
    output logic                                  udf_err_o
);

    localparam int unsigned LvlW = lvl_width(RD_ADDR_WIDTH);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(MEM_DEPTH);
    localparam logic [LvlW-1:0] LvlOne = LvlW'(1);
    localparam logic [RD_ADDR_WIDTH-1:0] AddrLast = RD_ADDR_WIDTH'(MEM_DEPTH - 1);

    rd_state_e                state_q;
    logic                     full_q;
    logic                     rd_valid_q;
    logic                     release_q;
    logic                     ovf_q;
    logic                     udf_q;
    logic [RD_ADDR_WIDTH-1:0] addr_q;
    logic [LvlW-1:0]          level_q;

    logic reload;
    logic grant;
    logic udf_set;
    logic ovf_set;

    always_comb begin
        reload  = full_q & ~full_i;
        grant   = rd_req_i & (state_q == StReady) & (level_q != '0) & ~reload & ~flush_i;
        // the reload cycle itself is not an underflow: the bank is just arriving
        udf_set = rd_req_i & (state_q != StReady) & ~reload;
        // flush discards the reload, so it cannot overwrite unread data either
        ovf_set = reload & (state_q == StReady) & (level_q != '0) & ~flush_i;
    end

    always_ff @(posedge rd_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StEmpty;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            release_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            addr_q     <= '0;
            level_q    <= '0;
        end else begin
            full_q     <= full_i;
            rd_valid_q <= grant;
            release_q  <= 1'b0;

            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (err_clr_i) begin
                udf_q <= 1'b0;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (err_clr_i) begin
                ovf_q <= 1'b0;
            end

            if (flush_i) begin
                state_q <= StEmpty;
                level_q <= '0;
                addr_q  <= '0;
            end else if (reload) begin
                state_q <= StReady;
                level_q <= LvlFull;
                addr_q  <= '0;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (full_i) begin
                            state_q <= StArmed;
                        end
                    end
                    StArmed: begin
                        state_q <= StArmed;
                    end
                    StReady: begin
                        if (grant) begin
                            addr_q  <= (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
                            level_q <= level_q - 1'b1;
                            if (level_q == LvlOne) begin
                                state_q   <= StRelease;
                                release_q <= 1'b1;
                            end
                        end
                    end
                    StRelease: begin
                        state_q <= StEmpty;
                    end
                    default: begin
                        state_q <= StEmpty;
                    end
                endcase
            end
        end
    end

    assign rd_en_o    = grant;
    assign rd_addr_o  = addr_q;
    assign rd_valid_o = rd_valid_q;
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign release_o  = release_q;
    assign ovf_err_o  = ovf_q;
    assign udf_err_o  = udf_q;

endmodule

// File: tb/tb_rd_fifo_ctrl.sv
// Scoreboard bench for rd_fifo_ctrl: a queue-based model of the unread bank predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_rd_fifo_ctrl;

    localparam int unsigned AW = 2;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          full;
    logic          flush;
    logic          rd_req;
    logic          err_clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   level;
    logic          rel_o;
    logic          ovf_err;
    logic          udf_err;

    always #5 clk = ~clk;

    rd_fifo_ctrl #(
        .RD_ADDR_WIDTH(AW),
        .MEM_DEPTH    (D)
    ) dut (
        .rd_clk_i  (clk),
        .reset_ni  (reset_n),
        .full_i    (full),
        .flush_i   (flush),
        .rd_req_i  (rd_req),
        .err_clr_i (err_clr),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_valid_o(rd_valid),
        .empty_o   (empty),
        .level_o   (level),
        .release_o (rel_o),
        .ovf_err_o (ovf_err),
        .udf_err_o (udf_err)
    );

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          valid;
        logic          empty;
        logic [AW:0]   level;
        logic          rel;
        logic          ovf;
        logic          udf;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // Reference model: the bank is a queue of still-unread addresses.
    int unsigned unread[$];
    bit          rel_pend;
    bit          m_ovf;
    bit          m_udf;
    bit          prev_full;
    bit          prev_grant;

    function automatic void model_reset();
        unread.delete();
        rel_pend   = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        prev_full  = 1'b0;
        prev_grant = 1'b0;
    endfunction

    function automatic void model_cycle();
        obs_t        e;
        bit          reload;
        bit          grant;
        bit          udf_set;
        bit          ovf_set;
        int unsigned n;
        int unsigned drop;
        n       = unread.size();
        reload  = prev_full && !full;
        grant   = rd_req && (n > 0) && !reload && !flush;
        e.en    = grant;
        e.addr  = (n > 0) ? AW'(unread[0]) : '0;
        e.valid = prev_grant;
        e.empty = (n == 0);
        e.level = (AW + 1)'(n);
        e.rel   = rel_pend;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);

        udf_set = rd_req && (n == 0) && !reload;
        ovf_set = reload && (n > 0) && !flush;
        m_udf = udf_set ? 1'b1 : (err_clr ? 1'b0 : m_udf);
        m_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);

        if (flush) begin
            unread.delete();
            rel_pend = 1'b0;
        end else if (reload) begin
            unread.delete();
            for (int i = 0; i < int'(D); i++) unread.push_back(i);
            rel_pend = 1'b0;
        end else if (grant) begin
            drop = unread.pop_front();
            rel_pend = (unread.size() == 0);
        end else begin
            rel_pend = 1'b0;
        end
        prev_full  = full;
        prev_grant = grant;
    endfunction

    task automatic step(input bit f, input bit fl, input bit rq, input bit ec);
        @(posedge clk);
        #1;
        full    = f;
        flush   = fl;
        rd_req  = rq;
        err_clr = ec;
        model_cycle();
    endtask

    // Reset lands mid-cycle; the monitor samples before the next clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        full    = 1'b0;
        flush   = 1'b0;
        rd_req  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        model_cycle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_cycle();
    endtask

    task automatic load_bank();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {rd_en, rd_addr, rd_valid, empty, level, rel_o, ovf_err, udf_err};
            checks++;
            if (a === e) begin
                passed++;
            end else begin
                $display("FAIL outputs cyc=%0d got en=%b addr=%0d vld=%b emp=%b lvl=%0d rel=%b ovf=%b udf=%b exp en=%b addr=%0d vld=%b emp=%b lvl=%0d rel=%b ovf=%b udf=%b",
                         cyc, a.en, a.addr, a.valid, a.empty, a.level, a.rel, a.ovf, a.udf,
                         e.en, e.addr, e.valid, e.empty, e.level, e.rel, e.ovf, e.udf);
            end
        end
    end

    initial begin
        bit nf;
        reset_n = 1'b0;
        full    = 1'b0;
        flush   = 1'b0;
        rd_req  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_cycle();

        // Basic drain
        load_bank();
        repeat (4) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Underflow and clear
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Overflow: reload with entries unread, request dropped
        load_bank();
        repeat (2) step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Flush mid-drain, then restart from address 0
        load_bank();
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        load_bank();
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        // Reset mid-drain
        load_bank();
        repeat (2) step(0, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0);

        // Reload landing on the release cycle
        load_bank();
        repeat (3) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                nf = full ^ ($urandom_range(99) < 25);
                step(nf, $urandom_range(99) < 3, $urandom_range(99) < 70,
                     $urandom_range(99) < 5);
            end
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
